// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT, MULTU, DIV and DIVU into HI/LO, and accepts MTHI/MTLO
// writes while idle. Operands are latched as magnitudes (signed ops) or raw
// values (unsigned ops). A RUN phase of WIDTH iterations follows, and then a
// single FIX cycle applies the sign correction and writes HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin the operation selected by op (sampled only in IDLE)
//   op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA    multiplicand / dividend, also MTHI/MTLO write data
//   opB    multiplier / divisor
//   mthi   write opA into HI (IDLE only)
//   mtlo   write opA into LO (IDLE only)
//   busy   high whenever the unit is not IDLE
//   done   one-cycle pulse; HI/LO hold the new result in that cycle
//   hi     HI register
//   lo     LO register
//
// Optional build macro: MULDIV_SINGLE_CYCLE_MUL_EN
//   If defined, MULT/MULTU use the native multiplier in a single RUN cycle.
//   Divide timing does not change, and HI/LO results match the default build.

module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_q, a_d;        // multiplicand magnitude / dividend shifter
  logic [WIDTH-1:0]   b_q, b_d;        // multiplier shifter / divisor magnitude
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Datapath temporaries
  logic               signed_op;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic [2*WIDTH-1:0] mul_full;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    a_d       = a_q;
    b_d       = b_q;
    orig_a_d  = orig_a_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = ~op[0];

    // Shift-add step: the product's upper half gains the multiplicand when
    // the current multiplier LSB is set, then the whole product shifts right.
    mul_addend = b_q[0] ? a_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Restoring divide step: remainder lives in acc[2W-1:W], quotient bits
    // shift into acc[W-1:0], dividend bits come from the MSB of a_q.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    mul_full = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_a_d = signed_op & opA[WIDTH-1];
          sign_b_d = signed_op & opB[WIDTH-1];
          a_d      = (signed_op & opA[WIDTH-1]) ? -opA : opA;
          b_d      = (signed_op & opB[WIDTH-1]) ? -opB : opB;
          orig_a_d = opA;
          acc_d    = '0;
        end else begin
          if (mthi) hi_d = opA;
          if (mtlo) lo_d = opA;
        end
      end

      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
        end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        if (!is_div_q) begin
          acc_d   = mul_full;
          state_d = FIX;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
`else
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
`endif
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = orig_a_q;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          lo_d = (sign_a_q ^ sign_b_q) ? -quot : quot;
          hi_d = sign_a_q ? -rem : rem;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      orig_a_q <= orig_a_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected HI/LO values come
// from 64-bit integer arithmetic on the operands.

module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    h = 32'h0;
    l = 32'h0;
    if (o == 2'b00) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
      h  = p[63:32];
      l  = p[31:0];
    end else if (o == 2'b01) begin
      p = {32'h0, a} * {32'h0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'h0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else begin
      if (o == 2'b10) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation from IDLE, checking busy/done timing every cycle and
  // that HI/LO stay put until the result lands. Optional hazard pulses
  // start/mthi/mtlo mid-operation; with_move raises mthi alongside start.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit hazard, input bit with_move);
    int lat;
    int hk;
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    lat = 33;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    if (!o[1]) lat = 2;
`endif
    hk = (lat > 5) ? 5 : lat - 1;
    start = 1'b1; op = o; opA = a; opB = b; mthi = with_move; mtlo = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    op = 2'($urandom); opA = $urandom; opB = $urandom;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (hazard && k == hk) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; opA = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (k < lat) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
          bad++;
          $display("FAIL %s run k=%0d: busy=%b done=%b hi=%h lo=%h, want busy=1 done=0 hi=%h lo=%h",
                   name, k, busy, done, hi, lo, exp_hi, exp_lo);
        end
      end else begin
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== eh || lo !== el) begin
          bad++;
          $display("FAIL %s result: busy=%b done=%b hi=%h lo=%h, want busy=0 done=1 hi=%h lo=%h",
                   name, busy, done, hi, lo, eh, el);
        end
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      bad++;
      $display("FAIL %s done_fall: done=%b busy=%b hi=%h lo=%h, want done=0 busy=0 hi=%h lo=%h",
               name, done, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; opA = '0; opB = '0; mthi = 1'b0; mtlo = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("multu_ffff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    run_op("div_by_zero", 2'b10, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    run_op("divu_by_zero", 2'b11, 32'h8765_4321, 32'h0, 1'b0, 1'b0);
    run_op("div_min_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 24; i++) begin
      run_op("random", 2'($urandom_range(0, 3)), pick_val(), pick_val(), 1'b0, 1'b0);
    end
  endtask

  task automatic test_moves();
    logic [31:0] v;
    mtlo = 1'b1; opA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mtlo = 1'b0;
    exp_lo = 32'hDEAD_BEEF;
    total++;
    if (lo !== exp_lo || hi !== exp_hi || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b, want lo=%h hi=%h done=0 busy=0",
               lo, hi, done, busy, exp_lo, exp_hi);
    end
    v = $urandom;
    mthi = 1'b1; opA = v;
    @(posedge clk); #1;
    mthi = 1'b0;
    exp_hi = v;
    total++;
    if (hi !== exp_hi || lo !== exp_lo || done !== 1'b0) begin
      bad++;
      $display("FAIL mthi: hi=%h lo=%h done=%b, want hi=%h lo=%h done=0", hi, lo, done, exp_hi, exp_lo);
    end
    v = $urandom;
    mthi = 1'b1; mtlo = 1'b1; opA = v;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    exp_hi = v;
    exp_lo = v;
    total++;
    if (hi !== exp_hi || lo !== exp_lo || done !== 1'b0) begin
      bad++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h done=%b, want hi=%h lo=%h done=0", hi, lo, done, exp_hi, exp_lo);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL move_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_hazards();
    run_op("hazard_divu", 2'b11, 32'd1000, 32'd7, 1'b1, 1'b0);
    run_op("hazard_mult", 2'b00, $urandom, $urandom, 1'b1, 1'b0);
    run_op("start_with_mthi", 2'b11, 32'd7, 32'd2, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op("b2b", 2'(i), $urandom, $urandom_range(1, 1000), 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 2'b10; opA = 32'h7654_3210; opB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset_multu", 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_moves();
    test_random_ops();
    test_hazards();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the same register-file operands as the ALU (opA = rs, opB = rt).
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and handles MTHI/MTLO writes.
- HI/LO outputs feed the MFHI/MFLO writeback mux.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin the operation selected by op. Sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA  input  WIDTH  multiplicand / dividend. Also the MTHI/MTLO write data.
- opB  input  WIDTH  multiplier / divisor.
- mthi  input  1  write opA into HI. Effective only in IDLE.
- mtlo  input  1  write opA into LO. Effective only in IDLE.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, hi=0, lo=0, busy=0, done=0. Applies immediately, including mid-operation; any partial result is discarded.
- States are IDLE, RUN and FIX.
- IDLE, start=1 at edge E0:
  - Latch operands as absolute values (signed ops) or raw (unsigned ops), latch op, clear the accumulator.
  - counter<=0, go to RUN.
- RUN:
  - One iteration per edge: multiply by shift-add, divide by restoring shift-subtract.
  - counter increments each edge; after WIDTH RUN edges, go to FIX.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - Go to IDLE with done<=1.
- done falls on the next edge.
- Latency: start sampled at E0, result and done visible after edge E0+WIDTH+1. That is 33 edges for WIDTH=32, with busy high for 33 cycles.
- hi/lo hold their old values throughout RUN; they change only at FIX, MTHI/MTLO or reset.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. MULT is signed two's complement.
- DIVU: lo = quotient, hi = remainder.
- DIV: quotient truncates toward zero, remainder takes the sign of the dividend.
- Divide by zero (DIV and DIVU): lo = all ones, hi = opA as latched (original, un-negated value).
- DIV of most-negative by -1: lo = 0x80000000, hi = 0.
- start while busy: ignored, no queuing.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: register updated at the next edge.
- start together with mthi/mtlo in IDLE: start wins, the move is dropped.
- mthi and mtlo together: both are written.
- op and operands may change after E0 without affecting the result.
- done never asserts for a move operation.

Optional Feature:
- MULDIV_SINGLE_CYCLE_MUL_EN defined:
  - MULT/MULTU compute the product with the native multiplier in one RUN cycle, then FIX.
  - done is visible after E0+2, busy is high for 2 cycles.
  - Divide timing is unchanged.
- MULDIV_SINGLE_CYCLE_MUL_EN undefined: multiply uses the WIDTH-iteration shift-add path with the same timing as divide.
- HI/LO values are identical in both builds.

Test Plan:
- MULTU opA=0xFFFFFFFF opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high 33 cycles, done single pulse after E0+33.
- MULT opA=0xFFFFFFFD (-3) opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MULDIV_SINGLE_CYCLE_MUL_EN: same values, done after E0+2.
- DIV opA=0xFFFFFFF9 (-7) opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opA=7 opB=2 -> lo=3, hi=1.
- DIV opA=0x12345678 opB=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV opA=0x80000000 opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazards:
  - start or mthi pulse during RUN -> no effect, hi/lo unchanged until FIX.
  - mtlo in IDLE with opA=0xDEADBEEF -> lo=0xDEADBEEF next cycle.
  - start+mthi same cycle -> only the operation result appears.
- rst_n low 10 cycles into a DIV -> busy, done, hi, lo = 0 immediately without a clock. After release, MULTU 3*5 -> lo=15, hi=0.
